// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Parametrised pipeline-stage register placed between two MIPS pipeline stages
// (IF/ID, ID/EX, EX/MEM, MEM/WB). It moves a DATA_W-bit datapath bundle and a
// CTRL_W-bit control bundle across the stage boundary with a valid/ready
// handshake. A two-entry skid buffer (main slot + skid slot) lets in_ready be
// decoded purely from registered state, so there is no combinational path
// from out_ready or in_valid to in_ready.
//
// Handshake: a transfer happens on a rising CLK edge where valid and ready are
// both high on that side (in_fire = in_valid & in_ready, out_fire =
// out_valid & out_ready). A producer must hold valid and its payload stable
// until it sees ready; valid never depends on ready.
//
// Ports:
//   CLK         in   clock, rising edge
//   reset       in   synchronous active-high reset (beats flush and clr_cnt)
//   flush       in   drop every held and incoming entry this cycle
//   in_valid    in   upstream entry valid
//   in_ready    out  stage can accept an entry (registered-state decode)
//   in_data     in   upstream datapath bundle
//   in_ctrl     in   upstream control bundle
//   out_valid   out  downstream entry valid (main slot valid bit)
//   out_ready   in   downstream accepts entry
//   out_data    out  main slot datapath register
//   out_ctrl    out  main slot control register, 0 when out_valid = 0
//   stall_cnt   out  saturating count of cycles with out_valid & !out_ready
//   clr_cnt     in   synchronous clear of stall_cnt (beats increment)
//   dbg_state_o out  current occupancy state (EMPTY/ONE/TWO) for observation
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
   parameter int DATA_W = 69,
   parameter int CTRL_W = 2,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              clr_cnt,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Occupancy state and the two storage slots
   state_t              state_q,      state_d;
   logic [DATA_W-1:0]   main_data_q,  main_data_d;
   logic [CTRL_W-1:0]   main_ctrl_q,  main_ctrl_d;
   logic                main_valid_q, main_valid_d;
   logic [DATA_W-1:0]   skid_data_q,  skid_data_d;
   logic [CTRL_W-1:0]   skid_ctrl_q,  skid_ctrl_d;
   logic                skid_valid_q, skid_valid_d;
   logic [CNT_W-1:0]    stall_cnt_q,  stall_cnt_d;

   logic                in_fire;
   logic                out_fire;

   // in_ready only looks at the registered state: the skid slot absorbs the
   // one entry that may arrive in the same cycle downstream stalls.
   assign in_ready    = (state_q != S_TWO);
   assign in_fire     = in_valid & in_ready;
   assign out_fire    = main_valid_q & out_ready;

   // Outputs come straight from the main slot registers.
   assign out_valid   = main_valid_q;
   assign out_data    = main_data_q;
   assign out_ctrl    = main_ctrl_q;
   assign stall_cnt   = stall_cnt_q;
   assign dbg_state_o = state_q;

   // ---------------------------------------------------------------------------
   // Next-state and slot update logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      main_data_d  = main_data_q;
      main_ctrl_d  = main_ctrl_q;
      main_valid_d = main_valid_q;
      skid_data_d  = skid_data_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_valid_d = skid_valid_q;

      case (state_q)
         S_EMPTY: begin
            if (in_fire) begin
               main_data_d  = in_data;
               main_ctrl_d  = in_ctrl;
               main_valid_d = 1'b1;
               state_d      = S_ONE;
            end
         end

         S_ONE: begin
            if (in_fire && out_fire) begin
               // Pass-through: the leaving entry is replaced in place.
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end else if (in_fire) begin
               // Downstream stalled: park the new entry behind the main slot.
               skid_data_d  = in_data;
               skid_ctrl_d  = in_ctrl;
               skid_valid_d = 1'b1;
               state_d      = S_TWO;
            end else if (out_fire) begin
               // Leave a bubble: ctrl is zeroed, datapath keeps stale bits.
               main_ctrl_d  = '0;
               main_valid_d = 1'b0;
               state_d      = S_EMPTY;
            end
         end

         S_TWO: begin
            // in_ready is low here, so in_valid cannot fire.
            if (out_fire) begin
               main_data_d  = skid_data_q;
               main_ctrl_d  = skid_ctrl_q;
               skid_ctrl_d  = '0;
               skid_valid_d = 1'b0;
               state_d      = S_ONE;
            end
         end

         default: begin
            // Unreachable encoding: recover to an empty stage.
            main_ctrl_d  = '0;
            main_valid_d = 1'b0;
            skid_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            state_d      = S_EMPTY;
         end
      endcase

      // Flush wins over the normal update. Any entry that fired in this cycle
      // is discarded; one that left via out_fire was already taken downstream.
      if (flush) begin
         main_ctrl_d  = '0;
         main_valid_d = 1'b0;
         skid_ctrl_d  = '0;
         skid_valid_d = 1'b0;
         state_d      = S_EMPTY;
      end
   end

   // ---------------------------------------------------------------------------
   // Stall counter: saturating, clear beats increment, flush has no effect.
   // ---------------------------------------------------------------------------
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (clr_cnt) begin
         stall_cnt_d = '0;
      end else if (main_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q      <= S_EMPTY;
         main_data_q  <= '0;
         main_ctrl_q  <= '0;
         main_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_ctrl_q  <= '0;
         skid_valid_q <= 1'b0;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         main_data_q  <= main_data_d;
         main_ctrl_q  <= main_ctrl_d;
         main_valid_q <= main_valid_d;
         skid_data_q  <= skid_data_d;
         skid_ctrl_q  <= skid_ctrl_d;
         skid_valid_q <= skid_valid_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

endmodule
